// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the master state type.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } mst_state_e;

endpackage

// File: rtl/ahb_wait_timer.sv
// Saturating data-phase wait-state counter; expired flags count == terminal.
// A terminal value of zero never expires.
module ahb_wait_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (terminal != '0) && (count_q == terminal);

endmodule

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: one valid/ready command becomes one
// NONSEQ SINGLE transfer, answered by a one-cycle response strobe.
//   state   | meaning
//   ST_IDLE | ready for a command, bus idle
//   ST_ADDR | address phase, NONSEQ driven until hready
//   ST_DATA | data phase, waiting for hready or timeout
module ahb_lite_master
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [1:0]        htrans,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam int              CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TERM    = CNT_W'(TIMEOUT_CYC);
    localparam logic [2:0]      MAX_SIZE = 3'($clog2(DATA_W / 8));

    mst_state_e        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic       tmr_clear, tmr_enable, tmr_expired;
    logic [7:0] low_mask;
    logic       cmd_legal;

    // Size and alignment only matter below bit 8 since hsize tops out at 7.
    always_comb begin
        low_mask  = (8'd1 << cmd_size) - 8'd1;
        cmd_legal = (cmd_size <= MAX_SIZE) && ((cmd_addr[7:0] & low_mask) == 8'd0);
    end

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        size_d        = size_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rsp_timeout_d = 1'b0;
                    if (cmd_legal) begin
                        write_d     = cmd_write;
                        addr_d      = cmd_addr;
                        size_d      = cmd_size;
                        wdata_d     = cmd_wdata;
                        rsp_error_d = 1'b0;
                        state_d     = ST_ADDR;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (hready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (hready) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = hresp;
                    rsp_rdata_d = write_q ? '0 : hrdata;
                    state_d     = ST_IDLE;
                end else if (tmr_expired) begin
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            addr_q        <= '0;
            size_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign tmr_clear  = (state_q == ST_ADDR) && hready;
    assign tmr_enable = (state_q == ST_DATA) && !hready;

    ahb_wait_timer #(.CNT_W(CNT_W)) u_wait_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (tmr_clear),
        .count_enable (tmr_enable),
        .terminal     (TERM),
        .expired      (tmr_expired)
    );

    assign cmd_ready   = (state_q == ST_IDLE);
    assign htrans      = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr       = addr_q;
    assign hwrite      = write_q;
    assign hsize       = size_q;
    assign hburst      = HBURST_SINGLE;
    assign hwdata      = ((state_q == ST_DATA) && write_q) ? wdata_q : '0;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
